// File: rtl/dcache_pkg.sv
// Shared types and constants for the write-through data cache and its MSHR controller.
package dcache_pkg;

  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned MEM_TAG_W = 4;
  localparam int unsigned BLK_W     = ADDR_W - 3;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {
    MSHR_INVALID = 2'd0,
    MSHR_ISSUE   = 2'd1,
    MSHR_WAIT    = 2'd2
  } mshr_state_e;

  typedef struct packed {
    mshr_state_e          state;
    logic [BLK_W-1:0]     blk_addr;
    logic [MEM_TAG_W-1:0] mem_tag;
  } mshr_entry_t;

  localparam mshr_entry_t MSHR_RST = '{state: MSHR_INVALID, blk_addr: '0, mem_tag: '0};

  // Byte address of the first byte of a block.
  function automatic logic [ADDR_W-1:0] blk_base(input logic [BLK_W-1:0] blk);
    return {blk, 3'b000};
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/data array: one combinational read port, one write port
// shared by line fills (unconditional) and store hits (only if the line is resident).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned CACHE_SETS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BLK_W-1:0]  rd_blk_i,
  output logic              rd_hit_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              fill_en_i,
  input  logic [BLK_W-1:0]  fill_blk_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              st_en_i,
  input  logic [BLK_W-1:0]  st_blk_i,
  input  logic [DATA_W-1:0] st_data_i
);

  localparam int unsigned IDX_W = $clog2(CACHE_SETS);
  localparam int unsigned TAG_W = BLK_W - IDX_W;

  logic              valid_q [CACHE_SETS];
  logic [TAG_W-1:0]  tag_q   [CACHE_SETS];
  logic [DATA_W-1:0] data_q  [CACHE_SETS];

  logic [IDX_W-1:0]  rd_idx, st_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, st_tag, wr_tag;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  assign rd_idx    = rd_blk_i[IDX_W-1:0];
  assign rd_tag    = rd_blk_i[BLK_W-1:IDX_W];
  assign st_idx    = st_blk_i[IDX_W-1:0];
  assign st_tag    = st_blk_i[BLK_W-1:IDX_W];
  assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  // Fill has priority; a store that misses the array leaves it untouched.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = fill_blk_i[IDX_W-1:0];
    wr_tag  = fill_blk_i[BLK_W-1:IDX_W];
    wr_data = fill_data_i;
    if (fill_en_i) begin
      wr_en = 1'b1;
    end else if (st_en_i && valid_q[st_idx] && (tag_q[st_idx] == st_tag)) begin
      wr_en   = 1'b1;
      wr_idx  = st_idx;
      wr_tag  = st_tag;
      wr_data = st_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '{default: 1'b0};
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      tag_q[wr_idx]   <= wr_tag;
      data_q[wr_idx]  <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_mshr_ctrl.sv
// Write-through, no-write-allocate D-cache front end with load-miss MSHRs and a fill broadcast.
// Optional DCACHE_MSHR_MERGE_EN: secondary misses to an in-flight block merge instead of stalling.
module dcache_mshr_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned MSHR_NUM   = 4,
  parameter int unsigned CACHE_SETS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsq2Dcache_ld_en_i,
  input  logic [ADDR_W-1:0]    lsq2Dcache_ld_addr_i,
  input  logic                 lsq2Dcache_st_en_i,
  input  logic [ADDR_W-1:0]    lsq2Dcache_st_addr_i,
  input  logic [DATA_W-1:0]    lsq2Dcache_st_data_i,
  output logic                 Dcache_hit_o,
  output logic [DATA_W-1:0]    Dcache_data_o,
  output logic                 Dcache_mshr_vld_o,
  output logic                 Dcache_mshr_ld_ack_o,
  output logic [ADDR_W-1:0]    Dcache_mshr_addr_o,
  output logic                 Dcache_mshr_st_ack_o,
  output logic                 Dcache_mshr_stall_o,
  output logic [1:0]           Dcache2mem_command_o,
  output logic [ADDR_W-1:0]    Dcache2mem_addr_o,
  output logic [DATA_W-1:0]    Dcache2mem_data_o,
  input  logic [MEM_TAG_W-1:0] mem2Dcache_response_i,
  input  logic [MEM_TAG_W-1:0] mem2Dcache_tag_i,
  input  logic [DATA_W-1:0]    mem2Dcache_data_i
);

  localparam int unsigned MSHR_IDX_W = $clog2(MSHR_NUM);

  mshr_entry_t mshr_q [MSHR_NUM];
  mshr_entry_t mshr_d [MSHR_NUM];
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [BLK_W-1:0]      ld_blk, st_blk;
  logic                  arr_hit;
  logic [DATA_W-1:0]     arr_data;
  logic                  full, ld_match, st_match;
  logic                  fill_v, alloc_found, iss_found;
  logic [MSHR_IDX_W-1:0] fill_idx, alloc_idx, iss_idx;
  logic                  ld_miss, ld_sec, stall, alloc, st_go, resp_ok;
  logic                  unused_c;

  assign ld_blk   = lsq2Dcache_ld_addr_i[ADDR_W-1:3];
  assign st_blk   = lsq2Dcache_st_addr_i[ADDR_W-1:3];
  assign unused_c = ^{lsq2Dcache_ld_addr_i[2:0], lsq2Dcache_st_addr_i[2:0]};

  dcache_array #(.CACHE_SETS(CACHE_SETS)) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_blk_i    (ld_blk),
    .rd_hit_o    (arr_hit),
    .rd_data_o   (arr_data),
    .fill_en_i   (fill_v),
    .fill_blk_i  (mshr_q[fill_idx].blk_addr),
    .fill_data_i (mem2Dcache_data_i),
    .st_en_i     (Dcache_mshr_st_ack_o),
    .st_blk_i    (st_blk),
    .st_data_i   (lsq2Dcache_st_data_i)
  );

  // CAM search over the MSHR file; lowest index wins each priority pick.
  always_comb begin
    full        = 1'b1;
    ld_match    = 1'b0;
    st_match    = 1'b0;
    fill_v      = 1'b0;
    fill_idx    = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    iss_found   = 1'b0;
    iss_idx     = '0;
    for (int i = 0; i < int'(MSHR_NUM); i++) begin
      if (mshr_q[i].state == MSHR_INVALID) begin
        full = 1'b0;
        if (!alloc_found) begin
          alloc_found = 1'b1;
          alloc_idx   = MSHR_IDX_W'(i);
        end
      end else begin
        if (mshr_q[i].blk_addr == ld_blk) ld_match = 1'b1;
        if (mshr_q[i].blk_addr == st_blk) st_match = 1'b1;
      end
      if (mshr_q[i].state == MSHR_ISSUE && !iss_found) begin
        iss_found = 1'b1;
        iss_idx   = MSHR_IDX_W'(i);
      end
      if (mshr_q[i].state == MSHR_WAIT && mshr_q[i].mem_tag == mem2Dcache_tag_i &&
          mem2Dcache_tag_i != '0 && !fill_v) begin
        fill_v   = 1'b1;
        fill_idx = MSHR_IDX_W'(i);
      end
    end
  end

  // Allocation, bus arbitration and MSHR next state.
  always_comb begin
    ld_miss = lsq2Dcache_ld_en_i & ~arr_hit;
    ld_sec  = ld_miss & ld_match;
`ifdef DCACHE_MSHR_MERGE_EN
    stall   = full | (lsq2Dcache_st_en_i & st_match);
`else
    stall   = full | (lsq2Dcache_st_en_i & st_match) | ld_sec;
`endif
    alloc   = ld_miss & ~ld_sec & ~stall & alloc_found;
    // A store waits out a fill cycle so its hit update never competes for the write port.
    st_go   = lsq2Dcache_st_en_i & ~st_match & ~fill_v;
    resp_ok = mem2Dcache_response_i != '0;

    mshr_d               = mshr_q;
    Dcache2mem_command_o = BUS_NONE;
    Dcache2mem_addr_o    = '0;
    Dcache2mem_data_o    = '0;
    Dcache_mshr_st_ack_o = 1'b0;

    if (st_go) begin
      Dcache2mem_command_o = BUS_STORE;
      Dcache2mem_addr_o    = blk_base(st_blk);
      Dcache2mem_data_o    = lsq2Dcache_st_data_i;
      Dcache_mshr_st_ack_o = resp_ok;
    end else if (iss_found) begin
      Dcache2mem_command_o = BUS_LOAD;
      Dcache2mem_addr_o    = blk_base(mshr_q[iss_idx].blk_addr);
      if (resp_ok) begin
        mshr_d[iss_idx].state   = MSHR_WAIT;
        mshr_d[iss_idx].mem_tag = mem2Dcache_response_i;
      end
    end

    if (fill_v) mshr_d[fill_idx].state = MSHR_INVALID;
    if (alloc) mshr_d[alloc_idx] = '{state: MSHR_ISSUE, blk_addr: ld_blk, mem_tag: '0};

    vld_d  = fill_v;
    addr_d = fill_v ? blk_base(mshr_q[fill_idx].blk_addr) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mshr_q <= '{default: MSHR_RST};
      vld_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      mshr_q <= mshr_d;
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  assign Dcache_hit_o         = lsq2Dcache_ld_en_i & arr_hit;
  assign Dcache_data_o        = Dcache_hit_o ? arr_data : '0;
  assign Dcache_mshr_stall_o  = stall;
  assign Dcache_mshr_vld_o    = vld_q;
  assign Dcache_mshr_ld_ack_o = vld_q;
  assign Dcache_mshr_addr_o   = addr_q;

endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// Directed vector bench for dcache_mshr_ctrl: cold miss/fill, stores, MSHR-full stall,
// store/MSHR conflict, secondary miss, bus retry, mid-miss reset and stale tags.
module tb_dcache_mshr_ctrl;
  import dcache_pkg::*;

  localparam logic [1:0] N = BUS_NONE;
  localparam logic [1:0] L = BUS_LOAD;
  localparam logic [1:0] S = BUS_STORE;
`ifdef DCACHE_MSHR_MERGE_EN
  localparam logic [63:0] SEC_STALL = 64'd0;
`else
  localparam logic [63:0] SEC_STALL = 64'd1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0, st_en = 1'b0;
  logic [63:0] ld_addr = '0, st_addr = '0, st_data = '0, mem_data = '0;
  logic [3:0]  resp = '0, mtag = '0;
  logic        hit, vld, ld_ack, st_ack, stall;
  logic [63:0] data, vaddr, maddr, mdata;
  logic [1:0]  cmd;

  int tests  = 0;
  int failed = 0;

  dcache_mshr_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .lsq2Dcache_ld_en_i    (ld_en),
    .lsq2Dcache_ld_addr_i  (ld_addr),
    .lsq2Dcache_st_en_i    (st_en),
    .lsq2Dcache_st_addr_i  (st_addr),
    .lsq2Dcache_st_data_i  (st_data),
    .Dcache_hit_o          (hit),
    .Dcache_data_o         (data),
    .Dcache_mshr_vld_o     (vld),
    .Dcache_mshr_ld_ack_o  (ld_ack),
    .Dcache_mshr_addr_o    (vaddr),
    .Dcache_mshr_st_ack_o  (st_ack),
    .Dcache_mshr_stall_o   (stall),
    .Dcache2mem_command_o  (cmd),
    .Dcache2mem_addr_o     (maddr),
    .Dcache2mem_data_o     (mdata),
    .mem2Dcache_response_i (resp),
    .mem2Dcache_tag_i      (mtag),
    .mem2Dcache_data_i     (mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ld_en, st_en;
    logic [63:0] ld_addr, st_addr, st_data, mdata_in;
    logic [3:0]  resp, tag;
    logic        e_hit, e_vld, e_ack, e_stall;
    logic [63:0] e_data, e_vaddr, e_maddr, e_mdata;
    logic [1:0]  e_cmd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
      input logic [63:0] r, le, la, se, sa, sd, rs, tg, md,
      input logic [63:0] eh, ed, ev, eva, ea, es, ec, ema, emd);
    vec_t v;
    v.rst = r[0];   v.ld_en = le[0]; v.ld_addr = la; v.st_en = se[0];
    v.st_addr = sa; v.st_data = sd;  v.resp = rs[3:0]; v.tag = tg[3:0];
    v.mdata_in = md;
    v.e_hit = eh[0]; v.e_data = ed; v.e_vld = ev[0]; v.e_vaddr = eva;
    v.e_ack = ea[0]; v.e_stall = es[0]; v.e_cmd = ec[1:0];
    v.e_maddr = ema; v.e_mdata = emd;
    return v;
  endfunction

  task automatic chk(input int row, input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL row %0d %s: got 0x%0h expected 0x%0h", row, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; ld_en = v.ld_en; ld_addr = v.ld_addr; st_en = v.st_en;
    st_addr = v.st_addr; st_data = v.st_data; resp = v.resp; mtag = v.tag;
    mem_data = v.mdata_in;
  endtask

  task automatic idle_inputs();
    ld_en = 1'b0; st_en = 1'b0; ld_addr = '0; st_addr = '0; st_data = '0;
    resp = '0; mtag = '0; mem_data = '0;
  endtask

  initial begin
    logic        seen;
    logic [63:0] got_addr;
    //          rst ld  ldaddr  st stadr   stdat  rsp tag mdata   hit data  vld vaddr   ack stl cmd maddr  mdata
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h100,  0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     3,  0,  0,      0, 0,     0, 0,      0, 0, L, 'h100,  0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  3,  'hAB,   0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h100,  0, 0,      0,     0,  0,  0,      1, 'hAB,  1, 'h100,  0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      1, 'h100,  'h55,  5,  0,  0,      0, 0,     0, 0,      1, 0, S, 'h100,  'h55));
    vq.push_back(mk(0, 1, 'h100,  0, 0,      0,     0,  0,  0,      1, 'h55,  0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      1, 'h400,  'h77,  1,  0,  0,      0, 0,     0, 0,      1, 0, S, 'h400,  'h77));
    vq.push_back(mk(0, 1, 'h100,  0, 0,      0,     0,  0,  0,      1, 'h55,  0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h0,    0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h8,    0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, L, 'h0,    0));
    vq.push_back(mk(0, 1, 'h10,   0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, L, 'h0,    0));
    vq.push_back(mk(0, 1, 'h18,   0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, L, 'h0,    0));
    vq.push_back(mk(0, 1, 'h20,   0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 1, L, 'h0,    0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     7,  0,  0,      0, 0,     0, 0,      0, 1, L, 'h0,    0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 1, L, 'h8,    0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  7,  'h11,   0, 0,     0, 0,      0, 1, L, 'h8,    0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  0,  0,      0, 0,     1, 'h0,    0, 0, L, 'h8,    0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     1,  0,  0,      0, 0,     0, 0,      0, 0, L, 'h8,    0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     2,  0,  0,      0, 0,     0, 0,      0, 0, L, 'h10,   0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     3,  0,  0,      0, 0,     0, 0,      0, 0, L, 'h18,   0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  1,  'h22,   0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  2,  'h33,   0, 0,     1, 'h8,    0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  3,  'h44,   0, 0,     1, 'h10,   0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h0,    0, 0,      0,     0,  9,  'h99,   1, 'h11,  1, 'h18,   0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h200,  0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     4,  0,  0,      0, 0,     0, 0,      0, 0, L, 'h200,  0));
    vq.push_back(mk(0, 0, 0,      1, 'h200,  'h99,  6,  0,  0,      0, 0,     0, 0,      0, 1, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      1, 'h200,  'h99,  6,  4,  'h88,   0, 0,     0, 0,      0, 1, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      1, 'h200,  'h99,  6,  0,  0,      0, 0,     1, 'h200,  1, 0, S, 'h200,  'h99));
    vq.push_back(mk(0, 1, 'h200,  0, 0,      0,     0,  0,  0,      1, 'h99,  0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h300,  0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h300,  0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, SEC_STALL, L, 'h300, 0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     8,  0,  0,      0, 0,     0, 0,      0, 0, L, 'h300,  0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     5,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  8,  'hCC,   0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h300,  0, 0,      0,     0,  0,  0,      1, 'hCC,  1, 'h300,  0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h500,  0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h508,  0, 0,      0,     'hA, 0, 0,      0, 0,     0, 0,      0, 0, L, 'h500,  0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     'hB, 0, 0,      0, 0,     0, 0,      0, 0, L, 'h508,  0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  'hA, 'hEE,  0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(1, 1, 'h500,  0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 0, 0,      0, 0,      0,     0,  'hB, 'hFF,  0, 0,     0, 0,      0, 0, N, 0,      0));
    vq.push_back(mk(0, 1, 'h508,  0, 0,      0,     0,  0,  0,      0, 0,     0, 0,      0, 0, N, 0,      0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vq[r]) begin
      drive(vq[r]);
      #2;
      chk(r, "hit",    64'(hit),    64'(vq[r].e_hit));
      chk(r, "data",   data,        vq[r].e_data);
      chk(r, "vld",    64'(vld),    64'(vq[r].e_vld));
      chk(r, "ld_ack", 64'(ld_ack), 64'(vq[r].e_vld));
      chk(r, "vaddr",  vaddr,       vq[r].e_vaddr);
      chk(r, "st_ack", 64'(st_ack), 64'(vq[r].e_ack));
      chk(r, "stall",  64'(stall),  64'(vq[r].e_stall));
      chk(r, "cmd",    64'(cmd),    64'(vq[r].e_cmd));
      chk(r, "maddr",  maddr,       vq[r].e_maddr);
      chk(r, "mdata",  mdata,       vq[r].e_mdata);
      @(posedge clk);
      #1;
    end

    // Fresh miss after reset (0x508 allocated by the last row): issue, fill, bounded wait for broadcast.
    idle_inputs();
    resp = 4'hC;
    #2;
    chk(100, "post_rst_cmd",   64'(cmd), 64'(L));
    chk(100, "post_rst_maddr", maddr,    64'h508);
    @(posedge clk);
    #1;
    resp = '0; mtag = 4'hC; mem_data = 64'h5A5A;
    #2;
    chk(101, "pre_fill_vld", 64'(vld), 64'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    seen = 1'b0;
    got_addr = '0;
    for (int k = 0; k < 5 && !seen; k++) begin
      #2;
      if (vld) begin
        seen = 1'b1;
        got_addr = vaddr;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk(102, "fill_seen", 64'(seen), 64'd1);
    chk(102, "fill_addr", got_addr,  64'h508);
    if (seen) begin
      @(posedge clk);
      #1;
    end
    ld_en = 1'b1; ld_addr = 64'h50C;
    #2;
    chk(103, "refill_hit",  64'(hit), 64'd1);
    chk(103, "refill_data", data,     64'h5A5A);
    chk(103, "refill_vld",  64'(vld), 64'd0);
    @(posedge clk);
    #1;
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
